div_seq_8: RTL and testbench

DIV_SEQ_8 -- requirements
Module: div_seq_8

---
 rtl/div_seq_8.sv | 132 +++++++++++++
 tb/tb_div_seq_8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/div_seq_8.sv
// div_seq_8 : sequential restoring divider, one quotient bit per clock.
//
// Ports
//   clk          single clock, all state updates on its rising edge
//   rst_n        synchronous active-low reset
//   start        division request, sampled only while idle
//   dividend     unsigned numerator, captured on acceptance
//   divisor      unsigned denominator, captured on acceptance
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   busy         high while running or in the completion cycle
//   done         one-cycle completion pulse
//   div_by_zero  set when the last completed operation had divisor == 0
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; results hold the previous completion
// S_RUN   | one restoring iteration per cycle (or the div-by-zero exit)
// S_DONE  | done pulse cycle; start is ignored here
module div_seq_8 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]   r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0] r_rem;
  logic [N-1:0] r_quo;
  logic [N-1:0] r_dvs;
  logic         r_dz;
  logic [N-1:0] r_quotient;
  logic [N-1:0] r_remainder;
  logic         r_done;
  logic         r_dbz;

  logic [N:0]   w_shift;
  logic         w_ge;
  logic [N-1:0] w_diff;
  logic [N-1:0] w_rem_nxt;
  logic [N-1:0] w_quo_nxt;

  // The shifted partial remainder can reach 2^N, so the compare is done
  // one bit wider than the operands. When it succeeds the difference is
  // below the divisor, so the low N bits of the subtraction are exact.
  assign w_shift   = {r_rem, r_quo[N-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_diff    = w_shift[N-1:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[N-1:0];
  assign w_quo_nxt = {r_quo[N-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= dividend;
            r_dvs   <= divisor;
            r_dz    <= (divisor == '0);
          end
        end
        S_RUN: begin
          if (r_dz) begin
            // Divide by zero: single pass through RUN, dividend is
            // still untouched in r_quo.
            r_quotient  <= '1;
            r_remainder <= r_quo;
            r_dbz       <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_quotient  <= w_quo_nxt;
              r_remainder <= w_rem_nxt;
              r_dbz       <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq_8.sv
// tb_div_seq_8 : directed and randomized checks of div_seq_8 (N = 8).
module tb_div_seq_8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  div_seq_8 #(.N(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation, checks latency, results and the done pulse width.
  task automatic run_op(input string tag, input int a, input int b,
                        input int exp_q, input int exp_r, input int exp_dz,
                        input int exp_lat);
    int cyc;
    dividend = a[7:0];
    divisor  = b[7:0];
    start    = 1'b1;
    tick();                       // acceptance edge k
    check({tag, " busy@k"}, busy, 1);
    start    = 1'b0;
    dividend = 8'hA5;             // post-acceptance changes must not matter
    divisor  = 8'h3C;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 20);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " remainder"}, remainder, exp_r);
    check({tag, " dbz"}, div_by_zero, exp_dz);
    tick();
    check({tag, " done low"}, done, 0);
    check({tag, " busy low"}, busy, 0);
  endtask

  initial begin
    int ndone;
    int ea, eb;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (3) tick();
    check("rst quotient", quotient, 0);
    check("rst remainder", remainder, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst dbz", div_by_zero, 0);

    // start accepted on the very first edge with rst_n high
    rst_n = 1'b1;
    run_op("100/7", 100, 7, 14, 2, 0, 8);
    run_op("255/1", 255, 1, 255, 0, 0, 8);
    run_op("255/255", 255, 255, 1, 0, 0, 8);
    run_op("5/9", 5, 9, 0, 5, 0, 8);
    run_op("0/3", 0, 3, 0, 0, 0, 8);
    run_op("200/128", 200, 128, 1, 72, 0, 8);
    run_op("37/0", 37, 0, 255, 37, 1, 1);
    run_op("10/3", 10, 3, 3, 1, 0, 8);

    // start held high continuously
    dividend = 8'd200;
    divisor  = 8'd9;
    start    = 1'b1;
    tick();                       // edge k
    dividend = 8'd77;
    divisor  = 8'd5;
    ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 9)  check("hold busy@k+9", busy, 0);
      if (i == 10) check("hold busy@k+10", busy, 1);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("hold done1 edge", i, 8);
          check("hold q1", quotient, 22);
          check("hold r1", remainder, 2);
        end else if (ndone == 2) begin
          check("hold done2 edge", i, 18);
          check("hold q2", quotient, 15);
          check("hold r2", remainder, 2);
        end
      end
      if (i == 12) begin
        check("hold q stable", quotient, 22);
        check("hold r stable", remainder, 2);
      end
    end
    start = 1'b0;
    check("hold done count", ndone, 2);
    repeat (4) tick();

    // reset in the middle of 100/7
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();                       // edge k
    start = 1'b0;
    repeat (3) tick();            // k+1..k+3
    rst_n = 1'b0;
    tick();                       // k+4
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst dbz", div_by_zero, 0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check("midrst no done", ndone, 0);
    check("midrst idle", busy, 0);
    run_op("50/6", 50, 6, 8, 2, 0, 8);

    // randomized against a golden model
    for (int n = 0; n < 1000; n++) begin
      ea = int'($urandom_range(0, 255));
      if (n % 4 == 0) eb = int'($urandom_range(128, 255));
      else if (n % 50 == 7) eb = 0;
      else eb = int'($urandom_range(0, 255));
      if (eb == 0) run_op("rand", ea, eb, 255, ea, 1, 1);
      else run_op("rand", ea, eb, ea / eb, ea % eb, 0, 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
